// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity mode
// constants (also used by the receiver) and a frame-length helper.
// The optional UART_TX_BREAK_EN macro adds the BREAK / BREAK_RECOV states.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP,
    STOP2
`ifdef UART_TX_BREAK_EN
    ,
    BREAK,
    BREAK_RECOV
`endif
  } tx_state_t;

  // Serial bit periods in one frame: start + data + optional parity + stops.
  function automatic int frame_bits(input int data_width, input int parity,
                                    input int stop_bits);
    return 1 + data_width + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Count-down bit-period generator. The counter reloads BAUD_DIV-1 on
// restart or after reaching zero; tick marks the last clock of a bit.
module uart_baud_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload at bit start, otherwise count down toward zero.
  always_comb begin
    if (restart || (cnt_q == '0)) begin
      cnt_d = CW'(BAUD_DIV - 1);
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-word holding buffer behind a valid/ready port,
// LSB-first shifter, optional parity, 1 or 2 stop bits, registered tx.
// Handshake: a word is taken on any rising edge where in_valid && in_ready;
// the producer keeps data_in stable while in_valid is high and in_ready low.
// Optional feature macro: UART_TX_BREAK_EN (adds break_req and line break).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
`endif

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  tx_done_q, tx_done_d;
  logic                  frame_end;
  logic                  load;
  logic                  restart;
  logic                  tick;
  logic                  brk;

`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
  assign restart = (state_q == IDLE) || (state_q == BREAK);
`else
  assign brk = 1'b0;
  assign restart = (state_q == IDLE);
`endif

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Next state, buffer fill/drain and shifter updates.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    frame_end   = 1'b0;
    load        = 1'b0;

    if (in_valid && in_ready) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) state_d = BREAK;
        else
`endif
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (PARITY != PAR_NONE) ? PARITY_BIT : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY_BIT: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (STOP_BITS == 2) state_d = STOP2;
          else frame_end = 1'b1;
        end
      end
      STOP2: begin
        if (tick) frame_end = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (!brk) begin
          state_d   = BREAK_RECOV;
          bit_cnt_d = '0;
        end
      end
      BREAK_RECOV: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) state_d = IDLE;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A pending break wins over a buffered word at the end of a frame.
    if (frame_end) begin
      if (hold_full_q && !brk) load = 1'b1;
      else state_d = IDLE;
    end

    // Move the buffered word into the shifter and freeze its parity.
    if (load) begin
      state_d     = START;
      shift_d     = hold_q;
      par_d       = (^hold_q) ^ (PARITY == PAR_ODD);
      hold_full_d = 1'b0;
    end
  end

  // Outputs: next line level, end-of-frame pulse, handshake and busy.
  always_comb begin
    case (state_d)
      START:      tx_d = 1'b0;
      DATA:       tx_d = shift_d[0];
      PARITY_BIT: tx_d = par_d;
`ifdef UART_TX_BREAK_EN
      BREAK:      tx_d = 1'b0;
`endif
      default:    tx_d = 1'b1;
    endcase
    tx_done_d = frame_end;
    in_ready  = !hold_full_q;
`ifdef UART_TX_BREAK_EN
    if ((state_q == BREAK) || (state_q == BREAK_RECOV)) in_ready = 1'b0;
`endif
    busy = (state_q != IDLE) || hold_full_q;
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four parameter lanes (8N1/16, 8E2/4, 5O2/3, 9E1/2),
// each with its own DUT, driver and serial monitor. The driver pushes the
// expected frame bit pattern on every handshake; the monitor decodes the
// line cycle by cycle and pops/compares when a start bit appears.
module tb_uart_tx;

  localparam int NL = 4;
  localparam int P_DW  [NL] = '{8, 8, 5, 9};
  localparam int P_PAR [NL] = '{0, 1, 2, 1};
  localparam int P_SB  [NL] = '{1, 2, 2, 1};
  localparam int P_BD  [NL] = '{16, 4, 3, 2};
  localparam int GLOBAL_LIMIT = 95000;

  logic clk;
  int   compared   = 0;
  int   mismatched = 0;

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int DW  = P_DW[g];
    localparam int PAR = P_PAR[g];
    localparam int SB  = P_SB[g];
    localparam int BD  = P_BD[g];
    localparam int FB  = 1 + DW + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FL  = FB * BD;

    logic          rst;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic          tx_done;
    logic [15:0]   exp_q[$];
    int            b2b_cnt = 0;
    bit            in_mon  = 1'b0;
    bit            done_f  = 1'b0;

    uart_tx #(
      .DATA_WIDTH(DW),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .BAUD_DIV  (BD)
    ) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef UART_TX_BREAK_EN
      .break_req(1'b0),
`endif
      .data_in (data_in),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done)
    );

    // Reference frame: start 0, data LSB-first, parity from popcount, stops 1.
    function automatic logic [15:0] model(input int w);
      logic [15:0] fr;
      int ones;
      int idx;
      fr   = '0;
      ones = 0;
      for (int i = 0; i < DW; i++) begin
        fr[1+i] = w[i];
        ones += w[i] ? 1 : 0;
      end
      idx = 1 + DW;
      if (PAR != 0) begin
        fr[idx] = ((ones % 2) == 1) ^ (PAR == 2);
        idx++;
      end
      for (int s = 0; s < SB; s++) fr[idx+s] = 1'b1;
      return fr;
    endfunction

    function automatic string nm(input string s);
      return $sformatf("L%0d_%s", g, s);
    endfunction

    // Driver: present a word, hold it until taken, then scramble data_in.
    task automatic send(input int w, input bit lat);
      int t;
      t = 0;
      @(negedge clk);
      data_in  = w[DW-1:0];
      in_valid = 1'b1;
      while (!in_ready && t < 2 * FL + 20) begin
        @(negedge clk);
        t++;
      end
      chk(nm("hs_timeout"), 32'(!in_ready), 0);
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back(model(w));
        #1;
        in_valid = 1'b0;
        data_in  = DW'($urandom);
        if (lat) begin
          @(negedge clk);
          chk(nm("lat_in_ready_low"), 32'(in_ready), 0);
          chk(nm("lat_busy_high"), 32'(busy), 1);
          chk(nm("lat_tx_still_high"), 32'(tx), 1);
          @(negedge clk);
          chk(nm("lat_tx_start_low"), 32'(tx), 0);
          chk(nm("lat_in_ready_back"), 32'(in_ready), 1);
        end
      end else begin
        in_valid = 1'b0;
      end
    endtask

    task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy || in_mon) && t < 3 * FL + 50) begin
        @(negedge clk);
        t++;
      end
      chk(nm({"drain_", name}), 32'(t >= 3 * FL + 50), 0);
      repeat (2) @(negedge clk);
    endtask

    // Stimulus.
    initial begin : drv
      int b0;
      rst      = 1'b1;
      in_valid = 1'b0;
      data_in  = '0;
      repeat (3) @(negedge clk);
      chk(nm("rst_tx"), 32'(tx), 1);
      chk(nm("rst_in_ready"), 32'(in_ready), 1);
      chk(nm("rst_busy"), 32'(busy), 0);
      chk(nm("rst_tx_done"), 32'(tx_done), 0);
      #2 rst = 1'b0;

      send(32'h55, 1'b1);
      wait_idle("55");
      send(32'hA7, 1'b0);
      wait_idle("A7");

      b0 = b2b_cnt;
      send(32'h01, 1'b0);
      send(32'h80, 1'b0);
      wait_idle("b2b");
      chk(nm("b2b_no_gap"), 32'(b2b_cnt), 32'(b0 + 1));

      // Reset in the middle of data bit 3 with a second word buffered.
      send(32'hFF, 1'b0);
      send(32'h00, 1'b0);
      repeat (BD * 4 + BD / 2 - 1) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk(nm("midrst_tx"), 32'(tx), 1);
      chk(nm("midrst_in_ready"), 32'(in_ready), 1);
      chk(nm("midrst_busy"), 32'(busy), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      send(32'h3C, 1'b1);
      wait_idle("3C");

      for (int i = 0; i < 64; i++) begin
        send(int'($urandom_range(0, (1 << DW) - 1)), 1'b0);
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2 * FL)) @(negedge clk);
      end
      wait_idle("random");
      done_f = 1'b1;
    end

    // Monitor: decode every cycle of each frame against the queued pattern.
    initial begin : mon
      logic [15:0] fr;
      logic [15:0] rxv;
      int  errs;
      bit  busy_bad, done_bad, aborted, chain;
      forever begin
        @(negedge clk);
        if (rst) continue;
        if (tx_done === 1'b1) chk(nm("tx_done_idle"), 32'(tx_done), 0);
        if (tx !== 1'b0) continue;
        chain = 1'b1;
        while (chain) begin
          chain  = 1'b0;
          in_mon = 1'b1;
          chk(nm("start_expected"), 32'(exp_q.size() != 0), 1);
          fr       = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hFFFE;
          rxv      = '0;
          errs     = 0;
          busy_bad = 1'b0;
          done_bad = 1'b0;
          aborted  = 1'b0;
          for (int k = 0; k < FL; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== fr[k/BD]) errs++;
            if ((k % BD) == (BD / 2)) rxv[k/BD] = tx;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (k > 0 && tx_done !== 1'b0) done_bad = 1'b1;
          end
          if (!aborted) begin
            chk(nm("frame_bits"), 32'(rxv), 32'(fr));
            chk(nm("frame_cycle_errs"), 32'(errs), 0);
            chk(nm("frame_busy_low"), 32'(busy_bad), 0);
            chk(nm("tx_done_early"), 32'(done_bad), 0);
            @(negedge clk);
            if (!rst) begin
              chk(nm("tx_done_end"), 32'(tx_done), 1);
              if (tx === 1'b0) begin
                chain = 1'b1;
                b2b_cnt++;
              end
            end
          end
          if (!chain) in_mon = 1'b0;
        end
      end
    end
  end

  // Wait for all lanes, then report.
  initial begin : report
    int t;
    t = 0;
    while (!(lane[0].done_f && lane[1].done_f && lane[2].done_f && lane[3].done_f)
           && t < GLOBAL_LIMIT) begin
      @(posedge clk);
      t++;
    end
    chk("global_timeout", 32'(t >= GLOBAL_LIMIT), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
